alu_issue_queue: RTL

Reservation-station front end for the integer ALU: buffers dispatched ALU operations, captures missing source operands from the result broadcast bus, and issues the oldest ready operation to the ALU each cycle. It drives the ALU's `arg1` / `arg2` / `aluop` inputs and sits between rename/dispatch and the ALU in the out-of-order core.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_iq_select.sv | 28 ++
 rtl/alu_issue_queue.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, default widths and issue-queue entry layout
// Contents: op code constants, default tag/data widths, entry field widths.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD         = 3'b000;
  localparam logic [OP_W-1:0] OP_SHIFT_LEFT  = 3'b001;
  localparam logic [OP_W-1:0] OP_SHIFT_RIGHT = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR         = 3'b011;
  localparam logic [OP_W-1:0] OP_OR          = 3'b100;
  localparam logic [OP_W-1:0] OP_AND         = 3'b101;

  localparam int DEF_TAG_W  = 6;
  localparam int DEF_DATA_W = 32;

  // Entry layout: valid | aluop | dest | src1 {tag, rdy, val} | src2 {tag, rdy, val}
  localparam int ENT_VALID_W = 1;
  localparam int ENT_RDY_W   = 1;

  function automatic int entry_w(input int tag_w, input int data_w);
    return ENT_VALID_W + OP_W + tag_w + 2 * (tag_w + ENT_RDY_W + data_w);
  endfunction

endpackage

// File: rtl/alu_iq_select.sv
// rtl/alu_iq_select.sv - oldest-ready priority encoder for the ALU issue queue
// Ports: req (ready bit per entry, index 0 oldest) -> grant (one-hot),
//        idx (granted index), any (some entry granted).
module alu_iq_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the youngest down so the lowest index wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - compacting reservation station feeding the integer ALU
// Ports: clk/rst (sync, active-high), flush; dispatch disp_* with disp_ready;
//        result broadcast cdb_valid/cdb_tag/cdb_val; registered issue outputs
//        issue_valid, arg1, arg2, aluop, issue_dest.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OP_W-1:0]   disp_aluop,
  input  logic [TAG_W-1:0]  disp_dest,
  input  logic [TAG_W-1:0]  disp_src1_tag,
  input  logic [TAG_W-1:0]  disp_src2_tag,
  input  logic              disp_src1_rdy,
  input  logic              disp_src2_rdy,
  input  logic [DATA_W-1:0] disp_src1_val,
  input  logic [DATA_W-1:0] disp_src2_val,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              issue_valid,
  output logic [DATA_W-1:0] arg1,
  output logic [DATA_W-1:0] arg2,
  output logic [OP_W-1:0]   aluop,
  output logic [TAG_W-1:0]  issue_dest
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [ENT_RDY_W-1:0] rdy;
    logic [DATA_W-1:0]    val;
  } src_t;

  typedef struct packed {
    logic [ENT_VALID_W-1:0] valid;
    logic [OP_W-1:0]        op;
    logic [TAG_W-1:0]       dest;
    src_t                   s1;
    src_t                   s2;
  } entry_t;

  // A not-ready source picks up a matching broadcast value.
  function automatic src_t snoop(input src_t s, input logic cv,
                                 input logic [TAG_W-1:0] ct,
                                 input logic [DATA_W-1:0] cd);
    src_t r;
    r = s;
    if (cv && !s.rdy[0] && s.tag == ct) begin
      r.rdy = 1'b1;
      r.val = cd;
    end
    return r;
  endfunction

  entry_t q     [DEPTH];
  entry_t woke  [DEPTH];
  entry_t q_nxt [DEPTH];
  entry_t new_ent;

  logic [DEPTH-1:0]  req;
  logic [DEPTH-1:0]  grant;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_any;
  logic              disp_fire;
  int                count;
  int                sel_pos;
  int                wr_pos;
  logic [DATA_W-1:0] sel_a1;
  logic [DATA_W-1:0] sel_a2;
  logic [OP_W-1:0]   sel_op;
  logic [TAG_W-1:0]  sel_dest;

  always_comb begin
    count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = q[i].valid[0] & q[i].s1.rdy[0] & q[i].s2.rdy[0];
      if (q[i].valid[0]) count = count + 1;
    end
    disp_ready = (count < DEPTH) && !rst;
    disp_fire  = disp_valid && disp_ready;
  end

  alu_iq_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .req   (req),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.op    = disp_aluop;
    new_ent.dest  = disp_dest;
    new_ent.s1    = snoop({disp_src1_tag, disp_src1_rdy, disp_src1_val},
                          cdb_valid, cdb_tag, cdb_val);
    new_ent.s2    = snoop({disp_src2_tag, disp_src2_rdy, disp_src2_val},
                          cdb_valid, cdb_tag, cdb_val);

    for (int i = 0; i < DEPTH; i++) begin
      woke[i]    = q[i];
      woke[i].s1 = snoop(q[i].s1, cdb_valid, cdb_tag, cdb_val);
      woke[i].s2 = snoop(q[i].s2, cdb_valid, cdb_tag, cdb_val);
    end

    // Wakeups are applied before the shift, so a woken entry keeps its
    // capture when it slides into its new slot.
    sel_pos = int'(sel_idx);
    for (int i = 0; i < DEPTH - 1; i++) begin
      q_nxt[i] = (sel_any && i >= sel_pos) ? woke[i+1] : woke[i];
    end
    q_nxt[DEPTH-1] = sel_any ? '0 : woke[DEPTH-1];

    // The new op goes to the first free slot after compaction.
    wr_pos = sel_any ? count - 1 : count;
    if (disp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == wr_pos) q_nxt[i] = new_ent;
      end
    end
  end

  always_comb begin
    sel_a1   = '0;
    sel_a2   = '0;
    sel_op   = '0;
    sel_dest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_a1   = q[i].s1.val;
        sel_a2   = q[i].s2.val;
        sel_op   = q[i].op;
        sel_dest = q[i].dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      issue_valid <= 1'b0;
      arg1        <= '0;
      arg2        <= '0;
      aluop       <= OP_ADD;
      issue_dest  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      issue_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      issue_valid <= sel_any;
      if (sel_any) begin
        arg1       <= sel_a1;
        arg2       <= sel_a2;
        aluop      <= sel_op;
        issue_dest <= sel_dest;
      end
    end
  end

endmodule
